// File: rtl/sti_pkg.sv
// sti_pkg: shared definitions for the STI serial path.
//   LEN_8/LEN_16/LEN_24/LEN_32 : cfg_length encodings
//   len_bits()                 : encoding -> frame length N in bits
//   sti_state_e                : receiver FSM states
//   sti_cfg_t                  : one frame-control set {length, fill, msb, low}
package sti_pkg;

  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} sti_state_e;

  typedef struct packed {
    logic [1:0] length;
    logic       fill;
    logic       msb;
    logic       low;
  } sti_cfg_t;

  function automatic logic [5:0] len_bits(input logic [1:0] len);
    logic [5:0] n;
    case (len)
      LEN_8:   n = 6'd8;
      LEN_16:  n = 6'd16;
      LEN_24:  n = 6'd24;
      default: n = 6'd32;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sti_rx_extract.sv
// sti_rx_extract: combinational recovery of the 16-bit word from an
// assembled frame F (bit k of F is frame bit k, already un-reversed).
//   i_frame  : frame word F, valid in F[N-1:0], upper bits don't care
//   i_cfg    : frame controls of the frame being decoded
//   o_data   : recovered 16-bit word
//   o_pad_nz : OR of the pad bits (N>16); only built with FILL_CHECK_EN,
//              otherwise constant 0
module sti_rx_extract
  import sti_pkg::*;
(
  input  logic [31:0] i_frame,
  input  sti_cfg_t    i_cfg,
  output logic [15:0] o_data,
  output logic        o_pad_nz
);

  always_comb begin
    o_data   = 16'h0000;
    o_pad_nz = 1'b0;
    case (i_cfg.length)
      LEN_8:   o_data = i_cfg.low ? {i_frame[7:0], 8'h00} : {8'h00, i_frame[7:0]};
      LEN_16:  o_data = i_frame[15:0];
      LEN_24: begin
        o_data = i_cfg.fill ? i_frame[23:8] : i_frame[15:0];
`ifdef FILL_CHECK_EN
        o_pad_nz = i_cfg.fill ? |i_frame[7:0] : |i_frame[23:16];
`endif
      end
      default: begin
        o_data = i_cfg.fill ? i_frame[31:16] : i_frame[15:0];
`ifdef FILL_CHECK_EN
        o_pad_nz = i_cfg.fill ? |i_frame[15:0] : |i_frame[31:16];
`endif
      end
    endcase
  end

endmodule

// File: rtl/sti_rx.sv
// sti_rx: STI serial-to-parallel receiver. Collects one frame per so_valid
// burst and recovers the 16-bit parallel word.
// Optional build macro FILL_CHECK_EN: flags nonzero pad bits on rx_fill_err.
//   clk, reset          : clock, synchronous active-high reset
//   cfg_load, cfg_*     : frame controls, captured into a pending register
//   so_data, so_valid   : serial input stream
//   rx_data             : recovered word, held between frames
//   rx_valid            : 1-cycle pulse, new rx_data
//   rx_err              : 1-cycle pulse, short frame aborted
//   rx_fill_err         : 1-cycle pulse with rx_valid, pad bits nonzero
//   rx_busy             : frame in progress
//   rx_frame_cnt        : good-frame counter, wraps
module sti_rx
  import sti_pkg::*;
#(
  parameter int FRM_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_load,
  input  logic [1:0]           cfg_length,
  input  logic                 cfg_fill,
  input  logic                 cfg_msb,
  input  logic                 cfg_low,
  input  logic                 so_data,
  input  logic                 so_valid,
  output logic [15:0]          rx_data,
  output logic                 rx_valid,
  output logic                 rx_err,
  output logic                 rx_fill_err,
  output logic                 rx_busy,
  output logic [FRM_CNT_W-1:0] rx_frame_cnt
);

  sti_state_e  r_state;
  logic [5:0]  r_bit_cnt;
  logic [31:0] r_shift;
  sti_cfg_t    r_pend, r_act;

  sti_cfg_t    w_cfg_in, w_cfg_use;
  logic        w_first, w_done, w_pad_nz;
  logic [5:0]  w_cnt_nxt, w_n;
  logic [31:0] w_shift_base, w_shift_nxt, w_frame;
  logic [15:0] w_data;

  always_comb begin
    w_cfg_in.length = cfg_length;
    w_cfg_in.fill   = cfg_fill;
    w_cfg_in.msb    = cfg_msb;
    w_cfg_in.low    = cfg_low;
  end

  assign w_first   = (r_state == IDLE) && so_valid;
  // Bit 0 uses the config it latches (cfg_load bypasses pending); later bits use active.
  assign w_cfg_use = (r_state == IDLE) ? (cfg_load ? w_cfg_in : r_pend) : r_act;
  assign w_n       = len_bits(w_cfg_use.length);

  // MSB-first shifts up from bit 0 so F lands in shift[N-1:0] directly.
  // LSB-first shifts down from bit 31, so F sits in shift[31:32-N] and is
  // right-aligned below.
  assign w_shift_base = w_first ? 32'h0 : r_shift;
  assign w_shift_nxt  = w_cfg_use.msb ? {w_shift_base[30:0], so_data}
                                      : {so_data, w_shift_base[31:1]};
  assign w_frame      = w_cfg_use.msb ? w_shift_nxt : (w_shift_nxt >> (6'd32 - w_n));
  assign w_cnt_nxt    = (w_first ? 6'd0 : r_bit_cnt) + 6'd1;
  assign w_done       = (r_state == RECV) && so_valid && (w_cnt_nxt == w_n);

  sti_rx_extract u_extract (
    .i_frame  (w_frame),
    .i_cfg    (w_cfg_use),
    .o_data   (w_data),
    .o_pad_nz (w_pad_nz)
  );

  assign rx_busy = (r_state == RECV);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_bit_cnt    <= 6'd0;
      r_shift      <= 32'h0;
      r_pend       <= '0;
      r_act        <= '0;
      rx_data      <= 16'h0000;
      rx_valid     <= 1'b0;
      rx_err       <= 1'b0;
      rx_fill_err  <= 1'b0;
      rx_frame_cnt <= '0;
    end else begin
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      rx_fill_err <= 1'b0;
      if (cfg_load) r_pend <= w_cfg_in;
      case (r_state)
        IDLE: begin
          if (so_valid) begin
            r_act     <= w_cfg_use;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= 6'd1;
            r_state   <= RECV;
          end
        end
        default: begin
          if (!so_valid) begin
            r_state   <= IDLE;
            r_bit_cnt <= 6'd0;
            rx_err    <= 1'b1;
          end else begin
            r_shift <= w_shift_nxt;
            if (w_done) begin
              r_state      <= IDLE;
              r_bit_cnt    <= 6'd0;
              rx_data      <= w_data;
              rx_valid     <= 1'b1;
              rx_fill_err  <= w_pad_nz;
              rx_frame_cnt <= rx_frame_cnt + FRM_CNT_W'(1);
            end else begin
              r_bit_cnt <= w_cnt_nxt;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sti_rx.sv
// tb_sti_rx: self-checking bench for sti_rx. A frame-level reference model
// (bit list -> frame word -> extraction table) predicts every output each
// cycle; directed frames add literal expectations that pin the model.
module tb_sti_rx;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset, cfg_load, cfg_fill, cfg_msb, cfg_low, so_data, so_valid;
  logic [1:0] cfg_length;
  logic [15:0] rx_data;
  logic rx_valid, rx_err, rx_fill_err, rx_busy;
  logic [W-1:0] rx_frame_cnt;

  always #5 clk = ~clk;

  sti_rx #(.FRM_CNT_W(W)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_length(cfg_length),
    .cfg_fill(cfg_fill), .cfg_msb(cfg_msb), .cfg_low(cfg_low),
    .so_data(so_data), .so_valid(so_valid), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_err(rx_err), .rx_fill_err(rx_fill_err),
    .rx_busy(rx_busy), .rx_frame_cnt(rx_frame_cnt)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit started = 0;

`ifdef FILL_CHECK_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  // ---------------- reference model ----------------
  logic [15:0] e_data;
  logic e_valid, e_err, e_fill, e_busy;
  logic [W-1:0] e_cnt;
  logic [4:0] m_pend, m_act;  // {length, fill, msb, low}
  bit m_in;
  int m_bits[$];

  always @(posedge clk) begin
    logic [31:0] f;
    logic [4:0] cin;
    int n;
    logic pad;
    cyc++;
    started = 1;
    cin = {cfg_length, cfg_fill, cfg_msb, cfg_low};
    if (reset) begin
      e_data = 0; e_valid = 0; e_err = 0; e_fill = 0; e_cnt = 0;
      m_pend = 0; m_act = 0; m_in = 0; m_bits.delete();
    end else begin
      e_valid = 0; e_err = 0; e_fill = 0;
      if (!m_in) begin
        if (so_valid) begin
          m_act = cfg_load ? cin : m_pend;
          m_bits.delete();
          m_bits.push_back(int'(so_data));
          m_in = 1;
        end
      end else if (so_valid) begin
        m_bits.push_back(int'(so_data));
        n = 8 * (int'(m_act[4:3]) + 1);
        if (m_bits.size() == n) begin
          f = 0;
          for (int k = 0; k < n; k++)
            if (m_act[1]) f[n-1-k] = m_bits[k][0];
            else          f[k]     = m_bits[k][0];
          pad = 0;
          case (n)
            8:  e_data = m_act[0] ? {f[7:0], 8'h00} : {8'h00, f[7:0]};
            16: e_data = f[15:0];
            24: begin
              e_data = m_act[2] ? f[23:8] : f[15:0];
              pad    = m_act[2] ? (f[7:0] != 0) : (f[23:16] != 0);
            end
            default: begin
              e_data = m_act[2] ? f[31:16] : f[15:0];
              pad    = m_act[2] ? (f[15:0] != 0) : (f[31:16] != 0);
            end
          endcase
          e_fill  = FILL_EN & pad;
          e_valid = 1;
          e_cnt   = e_cnt + 1'b1;
          m_in    = 0;
        end
      end else begin
        m_in  = 0;
        e_err = 1;
      end
      if (cfg_load) m_pend = cin;
    end
    e_busy = m_in;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      n_cmp++;
      if ({rx_data, rx_valid, rx_err, rx_fill_err, rx_busy, rx_frame_cnt} !==
          {e_data, e_valid, e_err, e_fill, e_busy, e_cnt}) begin
        n_bad++;
        $display("FAIL cycle%0d: got data=%h v=%b e=%b f=%b b=%b c=%0d want data=%h v=%b e=%b f=%b b=%b c=%0d",
                 cyc, rx_data, rx_valid, rx_err, rx_fill_err, rx_busy, rx_frame_cnt,
                 e_data, e_valid, e_err, e_fill, e_busy, e_cnt);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic set_cfg(input logic [1:0] len, input logic fill, input logic msb, input logic low);
    so_valid = 0;
    cfg_load = 1; cfg_length = len; cfg_fill = fill; cfg_msb = msb; cfg_low = low;
    @(posedge clk); #1;
    cfg_load = 0;
  endtask

  // Sends bits 0..cnt-1 of an n-bit frame f in the given order; optional
  // cfg_load with ncfg on bit cfg_at. Leaves so_valid high.
  task automatic drive_bits(input logic [31:0] f, input int n, input int cnt, input bit msb,
                            input int cfg_at, input logic [4:0] ncfg);
    for (int k = 0; k < cnt; k++) begin
      so_valid = 1;
      so_data  = msb ? f[n-1-k] : f[k];
      if (k == cfg_at) begin
        cfg_load = 1;
        {cfg_length, cfg_fill, cfg_msb, cfg_low} = ncfg;
      end else cfg_load = 0;
      @(posedge clk); #1;
    end
    cfg_load = 0;
  endtask

  task automatic pulse_reset();
    so_valid = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  int t1, t2, clen;
  logic [4:0] rc;

  initial begin
    reset = 1; cfg_load = 0; cfg_length = 0; cfg_fill = 0; cfg_msb = 0; cfg_low = 0;
    so_data = 0; so_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {rx_data, rx_valid, rx_err, rx_fill_err, rx_busy, rx_frame_cnt}, 0);
    reset = 0;

    // 1: 8-bit MSB first, both byte lanes
    set_cfg(2'b00, 0, 1, 0);
    drive_bits(32'hA5, 8, 8, 1, -1, 0); so_valid = 0;
    chk("t1_valid", rx_valid, 1);
    chk("t1_data", rx_data, 16'h00A5);
    chk("t1_model", e_data, 16'h00A5);
    @(posedge clk); #1;
    chk("t1_pulse", rx_valid, 0);
    set_cfg(2'b00, 0, 1, 1);
    drive_bits(32'hA5, 8, 8, 1, -1, 0); so_valid = 0;
    chk("t1_low", rx_data, 16'hA500);

    // 2: 16-bit LSB first after a reset
    pulse_reset();
    set_cfg(2'b01, 0, 0, 0);
    drive_bits(32'h1234, 16, 16, 0, -1, 0); so_valid = 0;
    chk("t2_data", rx_data, 16'h1234);
    chk("t2_cnt", rx_frame_cnt, 1);

    // 3: 24-bit fill=1, 32-bit fill=0
    set_cfg(2'b10, 1, 1, 0);
    drive_bits(32'hBEEF00, 24, 24, 1, -1, 0); so_valid = 0;
    chk("t3_24", rx_data, 16'hBEEF);
    chk("t3_fill", rx_fill_err, 0);
    set_cfg(2'b11, 0, 1, 0);
    drive_bits(32'h0000CAFE, 32, 32, 1, -1, 0); so_valid = 0;
    chk("t3_32", rx_data, 16'hCAFE);

    // 4: nonzero pad
    drive_bits(32'h00015A5A, 32, 32, 1, -1, 0); so_valid = 0;
    chk("t4_data", rx_data, 16'h5A5A);
    chk("t4_valid", rx_valid, 1);
    chk("t4_fill", rx_fill_err, FILL_EN);
    chk("t4_cnt", rx_frame_cnt, 4);

    // 5: short frame, then mid-frame cfg_load
    set_cfg(2'b01, 0, 1, 0);
    drive_bits(32'hFFFF, 16, 10, 1, -1, 0); so_valid = 0;
    @(posedge clk); #1;
    chk("t5_err", rx_err, 1);
    chk("t5_novalid", rx_valid, 0);
    chk("t5_hold", rx_data, 16'h5A5A);
    chk("t5_cnt", rx_frame_cnt, 4);
    @(posedge clk); #1;
    chk("t5_errpulse", rx_err, 0);
    drive_bits(32'h1357, 16, 16, 1, 5, 5'b00000); so_valid = 0;
    chk("t5_oldcfg", rx_data, 16'h1357);
    drive_bits(32'h3C, 8, 8, 0, -1, 0); so_valid = 0;
    chk("t5_newcfg", rx_data, 16'h003C);
    chk("t5_cnt2", rx_frame_cnt, 6);

    // 6: reset mid-frame, recovery, back-to-back
    set_cfg(2'b01, 0, 1, 0);
    drive_bits(32'hFFFF, 16, 5, 1, -1, 0);
    pulse_reset();
    chk("t6_reset", {rx_data, rx_valid, rx_err, rx_fill_err, rx_busy, rx_frame_cnt}, 0);
    set_cfg(2'b01, 0, 1, 0);
    chk("t6_noerr", rx_err, 0);
    drive_bits(32'h8001, 16, 16, 1, -1, 0); so_valid = 0;
    chk("t6_data", rx_data, 16'h8001);
    set_cfg(2'b00, 0, 1, 0);
    drive_bits(32'h11, 8, 8, 1, -1, 0);
    t1 = cyc;
    chk("t6_b2b_v1", rx_valid, 1);
    drive_bits(32'h22, 8, 8, 1, -1, 0);
    t2 = cyc; so_valid = 0;
    chk("t6_b2b_v2", rx_valid, 1);
    chk("t6_b2b_gap", t2 - t1, 8);
    chk("t6_b2b_data", rx_data, 16'h0022);

    // random traffic
    clen = 0;
    for (int i = 0; i < 400; i++) begin
      int n, cnt, cat, gap;
      if ($urandom_range(0, 3) == 0) begin
        rc = 5'($urandom);
        set_cfg(rc[4:3], rc[2], rc[1], rc[0]);
        clen = int'(rc[4:3]);
      end
      n   = 8 * (clen + 1);
      cnt = ($urandom_range(0, 9) == 0) ? $urandom_range(1, n - 1) : n;
      cat = -1;
      rc  = 5'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        cat  = $urandom_range(0, cnt - 1);
        clen = int'(rc[4:3]);
      end
      drive_bits($urandom, n, cnt, cfg_msb, cat, rc);
      gap = $urandom_range(0, 2);
      if (cnt < n && gap == 0) gap = 1;
      if (gap > 0) begin
        so_valid = 0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      if ($urandom_range(0, 49) == 0) begin
        pulse_reset();
        clen = 0;
      end
    end
    so_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
